rx_ana: RTL and testbench

RX_ANA -- requirements
Module: rx_ana

---
 rtl/rx_ana_pkg.sv | 30 +++
 rtl/crc16_modbus.sv | 17 +
 rtl/rx_ana.sv | 139 +++++++++++++
 tb/tb_rx_ana.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ana_pkg.sv
// rtl/rx_ana_pkg.sv - shared states, return codes and frame limits for the rx_ana frame decoder
package rx_ana_pkg;

  typedef enum logic [2:0] {
    ST_ID_H,
    ST_ID_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CRC_H,
    ST_CRC_L,
    ST_SKIP
  } state_t;

  localparam logic [7:0] RET_OK  = 8'h00;
  localparam logic [7:0] RET_LEN = 8'hE1;
  localparam logic [7:0] RET_CRC = 8'hE2;

  localparam int MIN_LEN     = 5;
  localparam int MAX_LEN     = 9;
  localparam int PAYLOAD_MAX = MAX_LEN - 4;

  // Payload arrives right-aligned in the shift register; the sensor ID must land in [39:32].
  function automatic logic [39:0] align_payload(input logic [39:0] sh, input logic [2:0] n);
    int sh_amt;
    sh_amt = 8 * (PAYLOAD_MAX - int'(n));
    return sh << sh_amt;
  endfunction

endpackage

// File: rtl/crc16_modbus.sv
// rtl/crc16_modbus.sv - combinational CRC-16/MODBUS single-byte update (reflected poly 0xA001)
module crc16_modbus (
  input  logic [7:0]  data,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_ana.sv
// rtl/rx_ana.sv - bus frame decoder: address match, length check, optional CRC, sensor command out
module rx_ana
  import rx_ana_pkg::*;
#(
  parameter logic [15:0] DEV_ID  = 16'h0001,
  parameter int          TIMEOUT = 256,
  parameter int          CRC_EN  = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  output logic [7:0]  ret_cmd,
  output logic        ret_cmd_flg,
  output logic [39:0] sen_cmd,
  output logic        sen_cmd_flag
);

  localparam int GW = $clog2(TIMEOUT + 1);

  state_t      state;
  logic        rx_flag_q;
  logic        byte_ok;
  logic [GW-1:0] gap_cnt;
  logic [15:0] crc;
  logic [15:0] crc_seed;
  logic [15:0] crc_nxt;
  logic [7:0]  id_h;
  logic [7:0]  len_h;
  logic [7:0]  crc_h;
  logic [15:0] len_w;
  logic        len_bad;
  logic [2:0]  pay_n;
  logic [2:0]  pay_cnt;
  logic [2:0]  pay_len;
  logic [39:0] shreg;

  assign byte_ok  = rx_flag & ~rx_flag_q;
  assign len_w    = {len_h, rx_data};
  assign len_bad  = (len_w < 16'(MIN_LEN)) || (len_w > 16'(MAX_LEN));
  assign pay_n    = 3'(len_w - 16'd4);
  // A new frame always restarts the CRC from the MODBUS init value.
  assign crc_seed = (state == ST_ID_H) ? 16'hFFFF : crc;

  crc16_modbus u_crc (
    .data    (rx_data),
    .crc_in  (crc_seed),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_ID_H;
      rx_flag_q    <= 1'b0;
      gap_cnt      <= '0;
      crc          <= '0;
      id_h         <= '0;
      len_h        <= '0;
      crc_h        <= '0;
      pay_cnt      <= '0;
      pay_len      <= '0;
      shreg        <= '0;
      ret_cmd      <= '0;
      ret_cmd_flg  <= 1'b0;
      sen_cmd      <= '0;
      sen_cmd_flag <= 1'b0;
    end else begin
      rx_flag_q    <= rx_flag;
      ret_cmd_flg  <= 1'b0;
      sen_cmd_flag <= 1'b0;

      if (byte_ok) begin
        gap_cnt <= '0;
      end else if (gap_cnt != GW'(TIMEOUT)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (!byte_ok && state != ST_ID_H && gap_cnt == GW'(TIMEOUT)) begin
        state <= ST_ID_H;
      end else if (byte_ok) begin
        case (state)
          ST_ID_H: begin
            id_h  <= rx_data;
            crc   <= crc_nxt;
            state <= ST_ID_L;
          end
          ST_ID_L: begin
            crc   <= crc_nxt;
            state <= ({id_h, rx_data} == DEV_ID) ? ST_LEN_H : ST_SKIP;
          end
          ST_LEN_H: begin
            len_h <= rx_data;
            crc   <= crc_nxt;
            state <= ST_LEN_L;
          end
          ST_LEN_L: begin
            crc <= crc_nxt;
            if (len_bad) begin
              ret_cmd     <= RET_LEN;
              ret_cmd_flg <= 1'b1;
              state       <= ST_SKIP;
            end else begin
              pay_cnt <= pay_n;
              pay_len <= pay_n;
              shreg   <= '0;
              state   <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            crc     <= crc_nxt;
            shreg   <= {shreg[31:0], rx_data};
            pay_cnt <= pay_cnt - 3'd1;
            if (pay_cnt == 3'd1) state <= ST_CRC_H;
          end
          ST_CRC_H: begin
            crc_h <= rx_data;
            state <= ST_CRC_L;
          end
          ST_CRC_L: begin
            state       <= ST_ID_H;
            ret_cmd_flg <= 1'b1;
            if (CRC_EN != 0 && {crc_h, rx_data} != crc) begin
              ret_cmd <= RET_CRC;
            end else begin
              ret_cmd      <= RET_OK;
              sen_cmd      <= align_payload(shreg, pay_len);
              sen_cmd_flag <= 1'b1;
            end
          end
          ST_SKIP: begin
            state <= ST_SKIP;
          end
          default: state <= ST_ID_H;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_ana.sv
// tb/tb_rx_ana.sv - randomized and directed frame checks of rx_ana against a frame-level reference model
module tb_rx_ana;

  localparam int TMO = 40;

  typedef logic [7:0] bq_t[$];

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic [7:0]  ret_cmd0, ret_cmd1;
  logic        ret_flg0, ret_flg1;
  logic [39:0] sen_cmd0, sen_cmd1;
  logic        sen_flg0, sen_flg1;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  rx_ana #(.DEV_ID(16'h0001), .TIMEOUT(TMO), .CRC_EN(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_flag(rx_flag), .rx_data(rx_data),
    .ret_cmd(ret_cmd0), .ret_cmd_flg(ret_flg0), .sen_cmd(sen_cmd0), .sen_cmd_flag(sen_flg0));

  rx_ana #(.DEV_ID(16'h0001), .TIMEOUT(TMO), .CRC_EN(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_flag(rx_flag), .rx_data(rx_data),
    .ret_cmd(ret_cmd1), .ret_cmd_flg(ret_flg1), .sen_cmd(sen_cmd1), .sen_cmd_flag(sen_flg1));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Pulse monitor: records every flagged value and counts protocol violations.
  logic [7:0]  ret_q0[$], ret_q1[$];
  logic [39:0] sen_q0[$], sen_q1[$];
  int   viol = 0;
  logic pr0 = 1'b0, ps0 = 1'b0, pr1 = 1'b0, ps1 = 1'b0;

  always @(negedge sys_clk) begin
    if (ret_flg0) ret_q0.push_back(ret_cmd0);
    if (sen_flg0) sen_q0.push_back(sen_cmd0);
    if (ret_flg1) ret_q1.push_back(ret_cmd1);
    if (sen_flg1) sen_q1.push_back(sen_cmd1);
    if (sen_flg0 && !(ret_flg0 && ret_cmd0 == 8'h00)) viol++;
    if (sen_flg1 && !(ret_flg1 && ret_cmd1 == 8'h00)) viol++;
    if ((ret_flg0 && pr0) || (sen_flg0 && ps0) || (ret_flg1 && pr1) || (sen_flg1 && ps1)) viol++;
    pr0 = ret_flg0; ps0 = sen_flg0; pr1 = ret_flg1; ps1 = sen_flg1;
  end

  function automatic logic [15:0] crc_ref(input bq_t f, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // kind: 0 no pulse, 1 good frame, 2 length error, 3 CRC error
  function automatic void predict(input bq_t f, input int crc_en, output int kind, output logic [39:0] sen);
    int n, len, plen;
    logic [15:0] id, lw;
    kind = 0;
    sen  = '0;
    n = f.size();
    if (n < 4) return;
    id = {f[0], f[1]};
    if (id != 16'h0001) return;
    lw  = {f[2], f[3]};
    len = int'(lw);
    if (len < 5 || len > 9) begin
      kind = 2;
      return;
    end
    if (n < 2 + len) return;
    plen = len - 4;
    for (int i = 0; i < plen; i++) sen[39 - 8*i -: 8] = f[4 + i];
    if (crc_en != 0 && crc_ref(f, 4 + plen) != {f[4 + plen], f[5 + plen]}) kind = 3;
    else kind = 1;
  endfunction

  task automatic add_crc(inout bq_t f);
    logic [15:0] c;
    c = crc_ref(f, f.size());
    f.push_back(c[15:8]);
    f.push_back(c[7:0]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_flag = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1;
    rx_flag = 1'b0;
    repeat (gap) @(posedge sys_clk);
    #1;
  endtask

  logic [7:0]  last_ret[2] = '{8'h00, 8'h00};
  logic [39:0] last_sen[2] = '{40'h0, 40'h0};

  task automatic run_frame(input string tag, input bq_t f, input int hold_fix, input int rst_after);
    int br[2], bs[2], bv, kind, nr, ns, hold;
    logic [7:0]  r_got, r_exp, r_now;
    logic [39:0] s_got, s_exp, s_now;
    bit did_rst;
    br[0] = ret_q0.size(); br[1] = ret_q1.size();
    bs[0] = sen_q0.size(); bs[1] = sen_q1.size();
    bv = viol;
    did_rst = 1'b0;
    foreach (f[i]) begin
      hold = (hold_fix > 0) ? hold_fix : int'($urandom_range(1, 3));
      send_byte(f[i], hold, int'($urandom_range(1, 6)));
      if (i == rst_after) begin
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        did_rst = 1'b1;
        break;
      end
    end
    repeat (TMO + 10) @(posedge sys_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (did_rst) begin
        kind = 0;
        s_exp = '0;
        last_ret[d] = 8'h00;
        last_sen[d] = '0;
      end else begin
        predict(f, d, kind, s_exp);
      end
      nr = (d == 0) ? ret_q0.size() - br[0] : ret_q1.size() - br[1];
      ns = (d == 0) ? sen_q0.size() - bs[0] : sen_q1.size() - bs[1];
      chk($sformatf("%s.d%0d.ret_pulses", tag, d), 64'(nr), 64'(kind != 0));
      chk($sformatf("%s.d%0d.sen_pulses", tag, d), 64'(ns), 64'(kind == 1));
      if (kind != 0 && nr > 0) begin
        r_got = (d == 0) ? ret_q0[br[0]] : ret_q1[br[1]];
        r_exp = (kind == 1) ? 8'h00 : (kind == 2) ? 8'hE1 : 8'hE2;
        chk($sformatf("%s.d%0d.ret_code", tag, d), 64'(r_got), 64'(r_exp));
        last_ret[d] = r_exp;
      end
      if (kind == 1 && ns > 0) begin
        s_got = (d == 0) ? sen_q0[bs[0]] : sen_q1[bs[1]];
        chk($sformatf("%s.d%0d.sen_cmd", tag, d), 64'(s_got), 64'(s_exp));
        last_sen[d] = s_exp;
      end
      r_now = (d == 0) ? ret_cmd0 : ret_cmd1;
      s_now = (d == 0) ? sen_cmd0 : sen_cmd1;
      chk($sformatf("%s.d%0d.ret_hold", tag, d), 64'(r_now), 64'(last_ret[d]));
      chk($sformatf("%s.d%0d.sen_hold", tag, d), 64'(s_now), 64'(last_sen[d]));
    end
    chk($sformatf("%s.pulse_rules", tag), 64'(viol - bv), 64'd0);
  endtask

  initial begin
    bq_t f;
    bq_t t;
    int  len, n;
    sys_rst = 1'b1;
    rx_flag = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst.ret_cmd0", 64'(ret_cmd0), 64'h0);
    chk("rst.sen_cmd0", 64'(sen_cmd0), 64'h0);
    chk("rst.flags0", 64'({ret_flg0, sen_flg0}), 64'h0);
    chk("rst.ret_cmd1", 64'(ret_cmd1), 64'h0);
    chk("rst.sen_cmd1", 64'(sen_cmd1), 64'h0);
    chk("rst.flags1", 64'({ret_flg1, sen_flg1}), 64'h0);
    @(posedge sys_clk);
    #1;

    t = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_ref.check_value", 64'(crc_ref(t, 9)), 64'h4B37);

    f = {8'h00, 8'h01, 8'h00, 8'h06, 8'h01, 8'h03, 8'h01, 8'h02};
    run_frame("basic", f, 0, -1);
    chk("basic.sen_const", 64'(sen_cmd0), 64'h01_0300_0000);

    f = {8'h00, 8'h02, 8'h00, 8'h06, 8'h01, 8'h03, 8'h01, 8'h02};
    run_frame("wrong_id", f, 0, -1);
    f = {8'h00, 8'h01, 8'h00, 8'h06, 8'h05, 8'h03};
    add_crc(f);
    run_frame("after_skip", f, 0, -1);

    f = {8'h00, 8'h01, 8'h00, 8'h0C, 8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01,
         8'h00, 8'h01, 8'h00, 8'h01};
    run_frame("len_long", f, 0, -1);
    chk("len_long.ret_const", 64'(ret_cmd0), 64'hE1);

    f = {8'h00, 8'h01, 8'h00, 8'h07, 8'h02, 8'h03, 8'h55};
    add_crc(f);
    run_frame("crc_good", f, 0, -1);
    f[f.size() - 1] ^= 8'h10;
    run_frame("crc_flip", f, 0, -1);
    chk("crc_flip.ret_const", 64'(ret_cmd1), 64'hE2);

    f = {8'h00, 8'h01, 8'h00, 8'h09, 8'h07, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    add_crc(f);
    run_frame("len9", f, 0, -1);
    chk("len9.sen_const", 64'(sen_cmd1), 64'h07_01AA_BBCC);

    f = {8'h00, 8'h01, 8'h00, 8'h06, 8'h09, 8'h03};
    add_crc(f);
    run_frame("held_reset", f, 3, 3);
    run_frame("held_after", f, 3, -1);

    for (int k = 0; k < 60; k++) begin
      f = {};
      f.push_back(8'h00);
      f.push_back(($urandom_range(0, 7) == 0) ? 8'h02 : 8'h01);
      case ($urandom_range(0, 11))
        0: len = 3;
        1: len = 4;
        2: len = 10;
        default: len = int'($urandom_range(5, 9));
      endcase
      f.push_back(8'h00);
      f.push_back(8'(len));
      if (len >= 5 && len <= 9) begin
        for (int i = 0; i < len - 4; i++) f.push_back(8'($urandom));
        if ($urandom_range(0, 2) != 0) add_crc(f);
        else begin
          f.push_back(8'($urandom));
          f.push_back(8'($urandom));
        end
      end else begin
        for (int i = 0; i < len - 2; i++) f.push_back(8'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) void'(f.pop_back());
      end
      run_frame($sformatf("rnd%0d", k), f, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
